ex_muldiv: RTL and testbench

- Parametrised multi-cycle multiply/divide/accumulate unit for the EX stage. Replaces the single-op iterative divider and the combinational multiplier.
- Accepts one HI/LO-class op at a time and holds the pipeline through stall_o until the result is ready.
- Emits a one-cycle HI/LO write pulse, OR-merged into the EX HI/LO outputs.
- Supports signed and unsigned MULT, DIV, MADD and MSUB, with a configurable multiply latency and an annul for flushed instructions.

---
 rtl/ex_muldiv.sv | 149 ++++++++++++++
 tb/tb_ex_muldiv.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/DIV/MADD/MSUB unit for the EX stage.
// It accepts one HI/LO op, stalls the pipeline until the result is ready,
// then emits a single-cycle HI/LO write strobe.
module ex_muldiv #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             annul_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             whilo_o,
    output logic             stall_o,
    output logic             busy_o,
    output logic             div_zero_o
);
    localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r, acc_hi, acc_lo;
    logic [WIDTH-1:0]   quo_r, rem_r, den_r;
    logic               neg_q, neg_r;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               dz_r;

    // Op decode on the incoming instruction: 010/011 are the divides; op[0] marks unsigned.
    logic               is_div_i, sgn_i;
    logic [WIDTH-1:0]   mag_a, mag_b;
    assign is_div_i = (op_i[2:1] == 2'b01);
    assign sgn_i    = !op_i[0];
    assign mag_a    = (sgn_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign mag_b    = (sgn_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Multiply path: extend the latched operands to 2*WIDTH so that one modular
    // product covers both signed and unsigned forms, then optionally accumulate.
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc, mul_res;
    always_comb begin
        ext_a   = op_r[0] ? {{WIDTH{1'b0}}, a_r} : {{WIDTH{a_r[WIDTH-1]}}, a_r};
        ext_b   = op_r[0] ? {{WIDTH{1'b0}}, b_r} : {{WIDTH{b_r[WIDTH-1]}}, b_r};
        prod    = ext_a * ext_b;
        acc     = {acc_hi, acc_lo};
        mul_res = !op_r[2] ? prod : (op_r[1] ? acc - prod : acc + prod);
    end

    // One restoring-division step: shift in the next dividend bit and keep the
    // difference only when it does not go negative.
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_n, quo_n;
    always_comb begin
        shifted = {rem_r, quo_r[WIDTH-1]};
        diff    = shifted - {1'b0, den_r};
        rem_n   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_n   = {quo_r[WIDTH-2:0], ~diff[WIDTH]};
    end

    // Control FSM and datapath registers; an annul abandons whatever is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            quo_r  <= '0;
            rem_r  <= '0;
            den_r  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
            dz_r   <= 1'b0;
        end else if (annul_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    op_r   <= op_i;
                    a_r    <= opdata1_i;
                    b_r    <= opdata2_i;
                    acc_hi <= hi_i;
                    acc_lo <= lo_i;
                    quo_r  <= mag_a;
                    den_r  <= mag_b;
                    rem_r  <= '0;
                    neg_q  <= sgn_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r  <= sgn_i && opdata1_i[WIDTH-1];
                    cnt    <= '0;
                    dz_r   <= 1'b0;
                    if (is_div_i && opdata2_i == '0) begin
                        res_hi <= opdata1_i;
                        res_lo <= '1;
                        dz_r   <= 1'b1;
                        state  <= DONE;
                    end else if (is_div_i) begin
                        state <= DIV;
                    end else begin
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (cnt == CW'(MUL_LAT - 1)) begin
                        {res_hi, res_lo} <= mul_res;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    rem_r <= rem_n;
                    quo_r <= quo_n;
                    if (cnt == CW'(WIDTH - 1)) begin
                        res_lo <= neg_q ? -quo_n : quo_n;
                        res_hi <= neg_r ? -rem_n : rem_n;
                        cnt    <= '0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write strobe is gated by annul so a flush in DONE suppresses the write.
    assign whilo_o    = (state == DONE) && !annul_i;
    assign hi_o       = whilo_o ? res_hi : '0;
    assign lo_o       = whilo_o ? res_lo : '0;
    assign div_zero_o = whilo_o && dz_r;
    assign busy_o     = (state != IDLE);
    assign stall_o    = !rst && !annul_i &&
                        (((state == IDLE) && start_i) || state == MUL || state == DIV);
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (WIDTH=32, MUL_LAT=2).
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, annul_i;
    logic [2:0]  op_i;
    logic [31:0] opdata1_i, opdata2_i, hi_i, lo_i;
    logic [31:0] hi_o, lo_o;
    logic        whilo_o, stall_o, busy_o, div_zero_o;

    ex_muldiv #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hi_i(hi_i), .lo_i(lo_i),
        .annul_i(annul_i), .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
        .stall_o(stall_o), .busy_o(busy_o), .div_zero_o(div_zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model for one operation.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, b, h, l);
        exp_t        e;
        logic [63:0] p, acc;
        e.dz = 1'b0;
        if (op[2:1] == 2'b01) begin
            e.lat = 33;
            if (b == 0) begin
                e.hi = a; e.lo = 32'hFFFFFFFF; e.dz = 1'b1; e.lat = 1;
            end else if (!op[0]) begin
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    e.lo = 32'h80000000; e.hi = 0;
                end else begin
                    e.lo = $signed(a) / $signed(b);
                    e.hi = $signed(a) % $signed(b);
                end
            end else begin
                e.lo = a / b;
                e.hi = a % b;
            end
        end else begin
            e.lat = 3;
            if (op[0]) p = {32'b0, a} * {32'b0, b};
            else       p = longint'($signed(a)) * longint'($signed(b));
            acc = {h, l};
            if (op[2] && op[1]) p = acc - p;
            else if (op[2])     p = acc + p;
            {e.hi, e.lo} = p;
        end
        return e;
    endfunction

    // Issue one op at the next negedge and follow it until the write strobe.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, h, l,
                          input bit scramble, output bit seen, output int lat,
                          output int stalls, output logic [31:0] rhi, rlo,
                          output logic rdz);
        @(negedge clk);
        op_i = op; opdata1_i = a; opdata2_i = b; hi_i = h; lo_i = l; start_i = 1'b1;
        seen = 0; lat = -1; stalls = 0; rhi = 'x; rlo = 'x; rdz = 'x;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (stall_o) stalls++;
            if (whilo_o) begin
                seen = 1; lat = c; rhi = hi_o; rlo = lo_o; rdz = div_zero_o;
                break;
            end
            if (scramble && c == 1) begin
                opdata1_i = $urandom; opdata2_i = $urandom; hi_i = $urandom; lo_i = $urandom;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 0; annul_i = 0; op_i = 0;
        opdata1_i = 0; opdata2_i = 0; hi_i = 0; lo_i = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({hi_o, lo_o, whilo_o, stall_o, busy_o, div_zero_o} !== 68'h0) begin
            n_bad++; $display("FAIL reset_hold: outputs=%h required 0", {hi_o, lo_o, whilo_o, stall_o, busy_o, div_zero_o});
        end
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({hi_o, lo_o, whilo_o, stall_o, busy_o, div_zero_o} !== 68'h0) begin
            n_bad++; $display("FAIL reset_release: outputs=%h required 0", {hi_o, lo_o, whilo_o, stall_o, busy_o, div_zero_o});
        end
    endtask

    task automatic test_mult();
        bit seen; int lat, st; logic [31:0] rh, rl; logic rd; exp_t e;
        sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 3});
        run_op(3'b000, 32'hFFFFFFFD, 32'd5, 0, 0, 0, seen, lat, st, rh, rl, rd);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || rh !== e.hi || rl !== e.lo || rd !== e.dz || lat !== e.lat) begin
            n_bad++; $display("FAIL mult: hi=%h lo=%h dz=%b lat=%0d required hi=%h lo=%h dz=%b lat=%0d", rh, rl, rd, lat, e.hi, e.lo, e.dz, e.lat);
        end
        n_cmp++;
        if (st !== 3 || stall_o !== 1'b0) begin
            n_bad++; $display("FAIL mult_stall: stall cycles=%0d stall_in_done=%b required 3/0", st, stall_o);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++; $display("FAIL mult_idle: busy=%b required 0", busy_o);
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops[4] = '{3'b011, 3'b010, 3'b010, 3'b010};
        logic [31:0] as[4]  = '{32'd100, 32'hFFFFFFF9, 32'h80000000, 32'd5};
        logic [31:0] bs[4]  = '{32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
        logic [31:0] ehi[4] = '{32'd2, 32'hFFFFFFFF, 32'h0, 32'd5};
        logic [31:0] elo[4] = '{32'hE, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
        logic        edz[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int          elat[4] = '{33, 33, 33, 1};
        bit seen; int lat, st; logic [31:0] rh, rl; logic rd; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{ehi[i], elo[i], edz[i], elat[i]});
            run_op(ops[i], as[i], bs[i], 0, 0, 0, seen, lat, st, rh, rl, rd);
            e = sb.pop_front();
            n_cmp++;
            if (!seen || rh !== e.hi || rl !== e.lo || rd !== e.dz || lat !== e.lat) begin
                n_bad++; $display("FAIL div_%0d: hi=%h lo=%h dz=%b lat=%0d required hi=%h lo=%h dz=%b lat=%0d", i, rh, rl, rd, lat, e.hi, e.lo, e.dz, e.lat);
            end
            n_cmp++;
            if (st !== elat[i]) begin
                n_bad++; $display("FAIL div_stall_%0d: stall cycles=%0d required %0d", i, st, elat[i]);
            end
        end
    endtask

    task automatic test_madd_msub();
        logic [2:0]  ops[4] = '{3'b110, 3'b101, 3'b100, 3'b111};
        logic [31:0] hs[4]  = '{32'd0, 32'd0, 32'h00000001, 32'h0};
        logic [31:0] ls[4]  = '{32'd10, 32'hFFFFFFFF, 32'h00000000, 32'h5};
        logic [31:0] as[4]  = '{32'd3, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs[4]  = '{32'd4, 32'd1, 32'd2, 32'd2};
        logic [31:0] ehi[4] = '{32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFE};
        logic [31:0] elo[4] = '{32'hFFFFFFFE, 32'd0, 32'hFFFFFFFE, 32'h7};
        bit seen; int lat, st; logic [31:0] rh, rl; logic rd; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{ehi[i], elo[i], 1'b0, 3});
            run_op(ops[i], as[i], bs[i], hs[i], ls[i], 0, seen, lat, st, rh, rl, rd);
            e = sb.pop_front();
            n_cmp++;
            if (!seen || rh !== e.hi || rl !== e.lo || rd !== e.dz || lat !== e.lat) begin
                n_bad++; $display("FAIL macc_%0d: hi=%h lo=%h dz=%b lat=%0d required hi=%h lo=%h dz=%b lat=%0d", i, rh, rl, rd, lat, e.hi, e.lo, e.dz, e.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen; int lat, st; logic [31:0] rh, rl; logic rd; exp_t e;
        logic [2:0] op; logic [31:0] a, b, h, l; bit scr;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom; h = $urandom; l = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 60);
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
            if ($urandom_range(0, 7) == 0) b = 0;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
            scr = (i % 4 == 0);
            sb.push_back(model(op, a, b, h, l));
            run_op(op, a, b, h, l, scr, seen, lat, st, rh, rl, rd);
            e = sb.pop_front();
            n_cmp++;
            if (!seen || rh !== e.hi || rl !== e.lo || rd !== e.dz || lat !== e.lat) begin
                n_bad++; $display("FAIL rand_%0d op=%0d a=%h b=%h: hi=%h lo=%h dz=%b lat=%0d required hi=%h lo=%h dz=%b lat=%0d", i, op, a, b, rh, rl, rd, lat, e.hi, e.lo, e.dz, e.lat);
            end
        end
    endtask

    task automatic test_annul();
        bit seen; int lat, st, wcount; logic [31:0] rh, rl; logic rd; exp_t e;
        // Flush mid-divide.
        @(negedge clk);
        op_i = 3'b011; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1; #1;
        n_cmp++;
        if (stall_o !== 1'b0 || whilo_o !== 1'b0 || busy_o !== 1'b1) begin
            n_bad++; $display("FAIL annul_div: stall=%b whilo=%b busy=%b required 0/0/1", stall_o, whilo_o, busy_o);
        end
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0; #1;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++; $display("FAIL annul_idle: busy=%b required 0", busy_o);
        end
        wcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (whilo_o) wcount++;
        end
        n_cmp++;
        if (wcount !== 0) begin
            n_bad++; $display("FAIL annul_nowrite: writes=%0d required 0", wcount);
        end
        // A fresh op after the flush completes normally.
        sb.push_back('{32'd1, 32'd333, 1'b0, 33});
        run_op(3'b011, 32'd1000, 32'd3, 0, 0, 0, seen, lat, st, rh, rl, rd);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || rh !== e.hi || rl !== e.lo || rd !== e.dz || lat !== e.lat) begin
            n_bad++; $display("FAIL annul_restart: hi=%h lo=%h dz=%b lat=%0d required hi=%h lo=%h dz=%b lat=%0d", rh, rl, rd, lat, e.hi, e.lo, e.dz, e.lat);
        end
        // Flush landing in DONE suppresses the write.
        @(negedge clk);
        op_i = 3'b000; opdata1_i = 32'd6; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (3) @(negedge clk);
        annul_i = 1'b1; #1;
        n_cmp++;
        if ({whilo_o, div_zero_o, hi_o, lo_o} !== 66'h0 || busy_o !== 1'b1) begin
            n_bad++; $display("FAIL annul_done: whilo=%b hi=%h lo=%h busy=%b required 0/0/0/1", whilo_o, hi_o, lo_o, busy_o);
        end
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0; #1;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++; $display("FAIL annul_done_idle: busy=%b required 0", busy_o);
        end
        // Annul together with start in IDLE accepts nothing.
        start_i = 1'b1; annul_i = 1'b1; #1;
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_bad++; $display("FAIL annul_start_stall: stall=%b required 0", stall_o);
        end
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0; #1;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++; $display("FAIL annul_start_busy: busy=%b required 0", busy_o);
        end
    endtask

    task automatic test_reset_mid();
        bit seen; int lat, st; logic [31:0] rh, rl; logic rd; exp_t e;
        @(negedge clk);
        op_i = 3'b001; opdata1_i = 32'd9; opdata2_i = 32'd9; start_i = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_busy: busy=%b required 1", busy_o);
        end
        rst = 1'b1; #1;
        n_cmp++;
        if ({hi_o, lo_o, whilo_o, stall_o, busy_o, div_zero_o} !== 68'h0) begin
            n_bad++; $display("FAIL rstmid_outputs: outputs=%h required 0", {hi_o, lo_o, whilo_o, stall_o, busy_o, div_zero_o});
        end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{32'h0, 32'd81, 1'b0, 3});
        run_op(3'b001, 32'd9, 32'd9, 0, 0, 0, seen, lat, st, rh, rl, rd);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || rh !== e.hi || rl !== e.lo || rd !== e.dz || lat !== e.lat) begin
            n_bad++; $display("FAIL rstmid_restart: hi=%h lo=%h dz=%b lat=%0d required hi=%h lo=%h dz=%b lat=%0d", rh, rl, rd, lat, e.hi, e.lo, e.dz, e.lat);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_madd_msub();
        test_back_to_back();
        test_annul();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
